// File: rtl/step_pkg.sv
// Shared types and default constants for the step/free-run pulse generator.
package step_pkg;

    localparam int DEB_CYCLES = 1_000_000;
    localparam int DEB_W      = 20;
    localparam int DIV_W      = 23;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } deb_state_t;

    // Top bit index of the divider compare window, saturated to the counter width.
    function automatic int div_top_bit(input logic [4:0] sel, input int width);
        return (int'(sel) > width - 1) ? width - 1 : int'(sel);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// CPU advance strobe: debounced single-step from step_in, or a free-running
// power-of-two divider of clk_in, with a running count of issued strobes.
module step_pulse_gen #(
    parameter int DEB_CYCLES = step_pkg::DEB_CYCLES,
    parameter int DEB_W      = step_pkg::DEB_W,
    parameter int DIV_W      = step_pkg::DIV_W
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        step_in,
    input  logic        run_en,
    input  logic [4:0]  div_sel,
    output logic        clk_en,
    output logic        step_level,
    output logic [15:0] pulse_cnt
);

    import step_pkg::*;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             step_s;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_cnt_nxt;
    logic             deb_done;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_mask;
    logic             div_hit;
    logic             strobe_nxt;
    logic             level_nxt;
    int               top_bit;

    sync_2ff u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (step_in),
        .q      (step_s)
    );

    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        deb_done    = 1'b0;
        unique case (state)
            S_LOW: begin
                if (step_s) begin
                    state_nxt   = S_RISE_CHK;
                    deb_cnt_nxt = '0;
                end
            end
            S_RISE_CHK: begin
                if (!step_s) begin
                    state_nxt = S_LOW;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = S_HIGH;
                    deb_done  = 1'b1;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!step_s) begin
                    state_nxt   = S_FALL_CHK;
                    deb_cnt_nxt = '0;
                end
            end
            S_FALL_CHK: begin
                if (step_s) begin
                    state_nxt = S_HIGH;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = S_LOW;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = S_LOW;
                deb_cnt_nxt = '0;
            end
        endcase
    end

    // Strobe when the low (top_bit+1) bits of the running divider are all ones.
    always_comb begin
        top_bit  = div_top_bit(div_sel, DIV_W);
        div_mask = '0;
        for (int i = 0; i < DIV_W; i++) begin
            div_mask[i] = (i <= top_bit);
        end
        div_hit = run_en && ((div_cnt & div_mask) == div_mask);
    end

    always_comb begin
        strobe_nxt = run_en ? div_hit : deb_done;
        level_nxt  = (state_nxt == S_HIGH) || (state_nxt == S_FALL_CHK);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= S_LOW;
            deb_cnt <= '0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (run_en) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            clk_en     <= 1'b0;
            step_level <= 1'b0;
        end else begin
            clk_en     <= strobe_nxt;
            step_level <= level_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
        end else if (strobe_nxt) begin
            pulse_cnt <= pulse_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with a short debounce window.
module tb_step_pulse_gen;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        step_in = 1'b0;
    logic        run_en = 1'b0;
    logic [4:0]  div_sel = 5'd0;
    logic        clk_en;
    logic        step_level;
    logic [15:0] pulse_cnt;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          tol = 0;
    int          exp_q[$];
    logic [15:0] exp_cnt = 16'd0;

    step_pulse_gen #(
        .DEB_CYCLES (4),
        .DEB_W      (4),
        .DIV_W      (23)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .step_in    (step_in),
        .run_en     (run_en),
        .div_sel    (div_sel),
        .clk_en     (clk_en),
        .step_level (step_level),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Every strobe is matched against the next expected edge number.
    always @(negedge clk_in) begin
        if (clk_en === 1'b1) begin
            int e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_clk_en: strobe at edge %0d, none expected", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc < e - tol || cyc > e + tol) begin
                    errors++;
                    $display("FAIL clk_en_time: strobe at edge %0d, expected %0d (+/-%0d)",
                             cyc, e, tol);
                end
            end
        end
    end

    task automatic test_reset();
        step_in = 1'b1;
        repeat (3) @(negedge clk_in);
        #1;
        checks++;
        if (clk_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_clk_en: got %b, expected 0", clk_en);
        end
        checks++;
        if (step_level !== 1'b0) begin
            errors++;
            $display("FAIL reset_step_level: got %b, expected 0", step_level);
        end
        checks++;
        if (pulse_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pulse_cnt: got %h, expected 0000", pulse_cnt);
        end
        step_in = 1'b0;
        @(negedge clk_in);
        rst = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic test_glitch();
        @(negedge clk_in);
        step_in = 1'b1;
        repeat (3) @(negedge clk_in);
        step_in = 1'b0;
        repeat (15) @(negedge clk_in);
        #1;
        checks++;
        if (step_level !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level: got %b, expected 0", step_level);
        end
        checks++;
        if (pulse_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL glitch_cnt: got %h, expected %h", pulse_cnt, exp_cnt);
        end
    endtask

    task automatic test_single_step();
        @(negedge clk_in);
        tol = 1;
        exp_q.push_back(cyc + 7);
        exp_cnt = exp_cnt + 16'd1;
        step_in = 1'b1;
        repeat (20) @(negedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL step_missing: %0d strobes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (pulse_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL step_cnt: got %h, expected %h", pulse_cnt, exp_cnt);
        end
        checks++;
        if (step_level !== 1'b1) begin
            errors++;
            $display("FAIL step_level_high: got %b, expected 1", step_level);
        end
        step_in = 1'b0;
        repeat (12) @(negedge clk_in);
        #1;
        checks++;
        if (step_level !== 1'b0 || pulse_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL step_fall: level %b cnt %h, expected 0 and %h",
                     step_level, pulse_cnt, exp_cnt);
        end
    endtask

    task automatic test_free_run();
        int base;
        @(negedge clk_in);
        tol = 0;
        div_sel = 5'd2;
        run_en = 1'b1;
        base = cyc;
        for (int i = 1; i <= 8; i++) exp_q.push_back(base + 8 * i);
        exp_cnt = exp_cnt + 16'd8;
        repeat (64) @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== exp_cnt || exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_div2: cnt %h pending %0d, expected %h and 0",
                     pulse_cnt, exp_q.size(), exp_cnt);
            exp_q.delete();
        end
        div_sel = 5'd3;
        exp_q.push_back(base + 80);
        exp_cnt = exp_cnt + 16'd1;
        repeat (16) @(negedge clk_in);
        run_en = 1'b0;
        @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== exp_cnt || exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_sel_change: cnt %h pending %0d, expected %h and 0",
                     pulse_cnt, exp_q.size(), exp_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_div_clamp();
        int base;
        @(negedge clk_in);
        tol = 0;
        div_sel = 5'd31;
        run_en = 1'b1;
        force dut.div_cnt = 23'h7FFFF0;
        base = cyc;
        exp_q.push_back(base + 16);
        exp_cnt = exp_cnt + 16'd1;
        #1;
        release dut.div_cnt;
        repeat (48) @(negedge clk_in);
        run_en = 1'b0;
        @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== exp_cnt || exp_q.size() != 0) begin
            errors++;
            $display("FAIL div_clamp: cnt %h pending %0d, expected %h and 0",
                     pulse_cnt, exp_q.size(), exp_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_run_with_step();
        int base;
        @(negedge clk_in);
        tol = 0;
        div_sel = 5'd1;
        run_en = 1'b1;
        base = cyc;
        for (int i = 1; i <= 12; i++) exp_q.push_back(base + 4 * i);
        exp_cnt = exp_cnt + 16'd12;
        for (int p = 0; p < 4; p++) begin
            step_in = ~step_in;
            repeat (12) @(negedge clk_in);
            #1;
            checks++;
            if (step_level !== step_in) begin
                errors++;
                $display("FAIL run_level_track: got %b, expected %b", step_level, step_in);
            end
        end
        run_en = 1'b0;
        @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== exp_cnt || exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_step_suppress: cnt %h pending %0d, expected %h and 0",
                     pulse_cnt, exp_q.size(), exp_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_in);
        step_in = 1'b1;
        repeat (4) @(negedge clk_in);
        rst = 1'b1;
        exp_cnt = 16'd0;
        #1;
        checks++;
        if (clk_en !== 1'b0 || step_level !== 1'b0 || pulse_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_outputs: en %b lvl %b cnt %h, expected 0 0 0000",
                     clk_en, step_level, pulse_cnt);
        end
        repeat (3) @(negedge clk_in);
        #1;
        checks++;
        if (clk_en !== 1'b0 || pulse_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_hold: en %b cnt %h, expected 0 0000", clk_en, pulse_cnt);
        end
        @(negedge clk_in);
        rst = 1'b0;
        tol = 1;
        exp_q.push_back(cyc + 7);
        exp_cnt = exp_cnt + 16'd1;
        repeat (20) @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== exp_cnt || exp_q.size() != 0 || step_level !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_rise: cnt %h pending %0d lvl %b, expected %h 0 1",
                     pulse_cnt, exp_q.size(), step_level, exp_cnt);
            exp_q.delete();
        end
        step_in = 1'b0;
        repeat (12) @(negedge clk_in);
    endtask

    task automatic test_wrap();
        @(negedge clk_in);
        force dut.pulse_cnt = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        #1;
        release dut.pulse_cnt;
        @(negedge clk_in);
        tol = 1;
        exp_q.push_back(cyc + 7);
        exp_cnt = exp_cnt + 16'd1;
        step_in = 1'b1;
        repeat (20) @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== 16'h0000 || exp_cnt !== 16'h0000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: cnt %h pending %0d, expected 0000 and 0",
                     pulse_cnt, exp_q.size());
            exp_q.delete();
        end
        step_in = 1'b0;
        repeat (12) @(negedge clk_in);
        @(negedge clk_in);
        exp_q.push_back(cyc + 7);
        exp_cnt = exp_cnt + 16'd1;
        step_in = 1'b1;
        repeat (20) @(negedge clk_in);
        #1;
        checks++;
        if (pulse_cnt !== exp_cnt || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_wrap: cnt %h pending %0d, expected %h and 0",
                     pulse_cnt, exp_q.size(), exp_cnt);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_step();
        test_free_run();
        test_div_clamp();
        test_run_with_step();
        test_reset_mid();
        test_wrap();
        repeat (4) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
